// File: rtl/axi_st_ll_rx_credit_fifo.sv
// axi_st_ll_rx_credit_fifo: show-ahead link-to-AXI-ST receive FIFO with credit return.
// Define LL_RX_DEBUG_STATUS_EN to enable the registered rx_debug_status fields.
module axi_st_ll_rx_credit_fifo #(
  parameter int DATA_WIDTH   = 128,
  parameter int TUSER_WIDTH  = 1,
  parameter int DEPTH        = 64,
  parameter int CREDIT_WIDTH = 4
) (
  input  logic                      clk_wr,
  input  logic                      rst_wr_n,
  input  logic                      rx_online,
  input  logic                      rx_pushbit,
  input  logic [DATA_WIDTH-1:0]     rx_tdata,
  input  logic [DATA_WIDTH/8-1:0]   rx_tkeep,
  input  logic [TUSER_WIDTH-1:0]    rx_tuser,
  input  logic                      rx_tlast,
  output logic                      user_tvalid,
  input  logic                      user_tready,
  output logic [DATA_WIDTH-1:0]     user_tdata,
  output logic [DATA_WIDTH/8-1:0]   user_tkeep,
  output logic [TUSER_WIDTH-1:0]    user_tuser,
  output logic                      user_tlast,
  output logic [CREDIT_WIDTH-1:0]   tx_credit_count,
  output logic [31:0]               rx_debug_status
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + DATA_WIDTH/8 + TUSER_WIDTH + 1;
  localparam logic [8:0] CAP = 9'((1 << CREDIT_WIDTH) - 1);
  logic [AW:0] wr_ptr, rd_ptr, pending, pending_next;
  logic [CREDIT_WIDTH-1:0] credit_next;
  logic [8:0] pend_w;
  logic online_q, full, empty, push, pop;
  logic [EW-1:0] mem [DEPTH];
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
  assign user_tvalid = !empty & rx_online;
  assign pop = user_tvalid & user_tready;
  assign push = rx_pushbit & rx_online & (!full | pop);
  assign {user_tlast, user_tuser, user_tkeep, user_tdata} = mem[rd_ptr[AW-1:0]];
  // Credits are charged against pending in the cycle they are issued, so the grant never overshoots.
  always_comb begin
    pend_w = 9'(pending);
    credit_next = (rx_online & online_q) ? CREDIT_WIDTH'(pend_w > CAP ? CAP : pend_w) : '0;
    pending_next = !rx_online ? '0
                 : !online_q ? (AW+1)'(DEPTH)
                 : pending + (AW+1)'(pop) - (AW+1)'(credit_next);
  end
  always_ff @(posedge clk_wr or negedge rst_wr_n)
    if (!rst_wr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pending <= '0;
      tx_credit_count <= '0;
      online_q <= 1'b0;
    end else begin
      online_q <= rx_online;
      pending <= pending_next;
      tx_credit_count <= credit_next;
      wr_ptr <= !rx_online ? '0 : wr_ptr + (AW+1)'(push);
      rd_ptr <= !rx_online ? '0 : rd_ptr + (AW+1)'(pop);
    end
  always_ff @(posedge clk_wr)
    if (push) mem[wr_ptr[AW-1:0]] <= {rx_tlast, rx_tuser, rx_tkeep, rx_tdata};
`ifdef LL_RX_DEBUG_STATUS_EN
  logic [15:0] pkt_cnt, pkt_next;
  logic ovf, ovf_next;
  logic [AW:0] occ_next;
  always_comb begin
    pkt_next = pkt_cnt + 16'(pop & user_tlast);
    ovf_next = ovf | (rx_pushbit & rx_online & full & !pop);
    occ_next = !rx_online ? '0 : wr_ptr + (AW+1)'(push) - rd_ptr - (AW+1)'(pop);
  end
  always_ff @(posedge clk_wr or negedge rst_wr_n)
    if (!rst_wr_n) begin
      pkt_cnt <= '0;
      ovf <= 1'b0;
      rx_debug_status <= '0;
    end else begin
      pkt_cnt <= pkt_next;
      ovf <= ovf_next;
      rx_debug_status <= {pkt_next, 8'(occ_next), 6'b0, rx_online, ovf_next};
    end
`else
  assign rx_debug_status = '0;
`endif
endmodule

// File: doc/axi_st_ll_rx_credit_fifo.md
AXI_ST_LL_RX_CREDIT_FIFO -- requirements
Module: axi_st_ll_rx_credit_fifo

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_WIDTH, 128: tdata bits; multiple of 8.
- TUSER_WIDTH, 1: tuser bits; at least 1.
- DEPTH, 64: FIFO entries; power of 2, 2..128.
- CREDIT_WIDTH, 4: credit-return field width; 1..8.
REQ-002 Ports (name, direction, width, meaning):
- clk_wr, in, 1: sole clock.
- rst_wr_n, in, 1: asynchronous active-low reset.
- rx_online, in, 1: link receive online.
- rx_pushbit, in, 1: link word valid.
- rx_tdata, in, DATA_WIDTH: link data.
- rx_tkeep, in, DATA_WIDTH/8: link keep.
- rx_tuser, in, TUSER_WIDTH: link user bits.
- rx_tlast, in, 1: link last.
- user_tvalid, out, 1: AXI-ST valid.
- user_tready, in, 1: AXI-ST ready.
- user_tdata / user_tkeep / user_tuser / user_tlast, out, widths as rx_*: AXI-ST payload.
- tx_credit_count, out, CREDIT_WIDTH: credits returned this cycle.
- rx_debug_status, out, 32: debug status.
REQ-003 One clock, clk_wr; rst_wr_n is asynchronous assert, active-low; all state is in the clk_wr domain.

Function
REQ-004 FIFO is show-ahead; pointers are log2(DEPTH)+1 bits with a wrap bit. Full = equal index and differing wrap bit; empty = pointers equal.
REQ-005 Push = rx_pushbit & rx_online & (!full | pop). A push on full with a simultaneous pop is accepted.
REQ-006 Push on full without a pop drops the word, leaves the pointers unchanged, and sets sticky overflow.
REQ-007 user_tvalid = !empty & rx_online, combinational. Pop = user_tvalid & user_tready. Payload holds stable while valid and not ready.
REQ-008 Latency: a word pushed in cycle N is presented with user_tvalid in cycle N+1 if the FIFO was empty; words drain in strict push order.
REQ-009 Pending-credit counter is log2(DEPTH)+1 bits.
- Loads DEPTH in the first cycle rx_online is seen high after being low or after reset.
- Otherwise each cycle: pending_next = pending + pop - tx_credit_count.
REQ-010 tx_credit_count = rx_online ? min(pending, 2^CREDIT_WIDTH-1) : 0, registered. With DEPTH=64, CREDIT_WIDTH=4 the initial grant is 15,15,15,15,4 over five cycles.
REQ-011 Pops during initial-grant drain add to pending. Pending never exceeds DEPTH. Total credits returned while online never exceed DEPTH plus pops.
REQ-012 rx_online falling edge (high to low), next clock:
- both pointers reset to 0 (flush);
- pending reset to 0;
- tx_credit_count forced to 0;
- user_tvalid already low via REQ-007.
Sticky overflow is retained.
REQ-013 rx_online low for one cycle between highs produces one flush and one full DEPTH re-grant.

Reset
REQ-014 rst_wr_n low asynchronously clears:
- pointers, pending, tx_credit_count, online-edge register, overflow and packet counter;
- user_tvalid=0, tx_credit_count=0, rx_debug_status=0.
FIFO storage is not reset; user_t* payload is don't-care while user_tvalid=0.
REQ-015 Reset deassertion mid-traffic: the first push is accepted only from the first clock edge after release with rx_online high.

Configuration
REQ-016 Macro LL_RX_DEBUG_STATUS_EN defined: rx_debug_status is registered with these fields:
- [31:16] wrapping count of popped words with tlast=1;
- [15:8] FIFO occupancy, zero-extended;
- [7:2] zero;
- [1] rx_online;
- [0] sticky overflow.
REQ-017 Macro undefined: rx_debug_status is tied to 0, and the packet counter, occupancy and overflow logic are not synthesised. All other behaviour is identical.

Verification
REQ-018 Reset, then rx_online high, DEPTH=64, CREDIT_WIDTH=4 -> tx_credit_count 15,15,15,15,4, then 0.
REQ-019 Push 64 words with user_tready=0, then a 65th push -> user_tvalid=1, the first word is presented, the 65th is dropped and rx_debug_status[0]=1. With user_tready=1, all 64 words drain in order and 64 credits return.
REQ-020 FIFO full, push and pop in the same cycle -> push accepted, occupancy stays 64, no overflow.
REQ-021 8 words buffered, 3 with tlast=1, then rx_online drops -> user_tvalid=0 next cycle and occupancy=0. rx_online back high -> a fresh 64-credit grant and packet count unchanged.
REQ-022 Pop 3 tlast words with LL_RX_DEBUG_STATUS_EN defined -> rx_debug_status[31:16]=3. Same stimulus with the macro undefined -> rx_debug_status=0 throughout.
REQ-023 Assert rst_wr_n low mid-burst, asynchronously between edges -> outputs are 0 immediately, before the next clk_wr edge.
